// File: rtl/lcd_wr_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_wr_ctrl
// HD44780-style character-LCD write sequencer. It accepts one byte plus an RS
// flag per valid/ready handshake and generates the LCD bus timing: setup, an EN
// pulse, hold, and then the command execution wait. Clear/home commands
// (rs=0, data 0x01..0x03) get the long execution wait.
//
// Optional feature (macro LCD_INIT_EN): after reset the sequencer waits
// T_PWR_CYC cycles and then issues the init commands 0x38, 0x0C, 0x01, 0x06
// by itself. Ready stays low throughout, and o_done does not pulse for these
// writes. Without the macro, IDLE is entered directly from reset.
//
// Ports:
//   i_clk       system clock
//   i_reset     asynchronous active-low reset
//   i_wr_vld    write request valid
//   i_wr_rs     register select (0 = command, 1 = data)
//   i_wr_data   byte to write
//   o_wr_rdy    ready to accept a request (high only in IDLE)
//   o_done      one-cycle pulse when a write and its wait complete
//   i_lcd_on    backlight/power enable from the CPU
//   o_lcd_on    i_lcd_on delayed by one cycle
//   o_lcd_data  LCD data bus (registered)
//   o_lcd_rs    LCD RS (registered)
//   o_lcd_rw    LCD R/W, tied to 0 (write-only)
//   o_lcd_en    LCD EN (registered)
// -----------------------------------------------------------------------------
module lcd_wr_ctrl #(
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_CMD_CYC   = 2000,
  parameter int unsigned T_CLR_CYC   = 82000,
  parameter int unsigned T_PWR_CYC   = 750000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_vld,
  input  logic       i_wr_rs,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_rdy,
  output logic       o_done,
  input  logic       i_lcd_on,
  output logic       o_lcd_on,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_CMD_CYC)),
                                       max2(T_CLR_CYC, T_PWR_CYC));
  localparam int CNT_W = $clog2(T_MAX + 1);

  // Each phase loads N-1 on entry and leaves when the counter reads zero,
  // so a phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(T_CLR_CYC - 1);

`ifdef LCD_INIT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_PWR
  } state_e;

  localparam state_e           RST_STATE = S_PWR;
  localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(T_PWR_CYC - 1);
  localparam logic             RST_RDY   = 1'b0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  logic [1:0] init_idx_q;
  logic       init_busy_q;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT
  } state_e;

  localparam state_e           RST_STATE = S_IDLE;
  localparam logic [CNT_W-1:0] RST_CNT   = '0;
  localparam logic             RST_RDY   = 1'b1;
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_q;
  logic             done_q;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             en_q;
  logic             lcd_on_q;
  logic             is_clr;

  // Clear (0x01) and return-home (0x02/0x03) commands need the long wait.
  assign is_clr = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values, regardless of statement order.
  // The asynchronous reset clears EN the moment i_reset falls, without waiting
  // for a clock edge, so an interrupted write never leaves EN high.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      rdy_q   <= RST_RDY;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx_q  <= 2'd0;
      init_busy_q <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_wr_vld && rdy_q) begin
            data_q  <= i_wr_data;
            rs_q    <= i_wr_rs;
            rdy_q   <= 1'b0;
            cnt_q   <= SETUP_LD;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            cnt_q   <= EN_LD;
            state_q <= S_EN_HI;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_EN_HI: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            cnt_q   <= HOLD_LD;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cnt_q   <= is_clr ? CLR_LD : CMD_LD;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
            if (init_busy_q) begin
              if (init_idx_q == 2'd3) begin
                // Last init command finished: hand the bus to the CPU.
                init_busy_q <= 1'b0;
                rdy_q       <= 1'b1;
                state_q     <= S_IDLE;
              end else begin
                // Chain straight into the next init command.
                init_idx_q <= init_idx_q + 2'd1;
                data_q     <= init_cmd(init_idx_q + 2'd1);
                rs_q       <= 1'b0;
                cnt_q      <= SETUP_LD;
                state_q    <= S_SETUP;
              end
            end else begin
              rdy_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
`else
            rdy_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef LCD_INIT_EN
        S_PWR: begin
          if (cnt_q == '0) begin
            data_q  <= init_cmd(2'd0);
            rs_q    <= 1'b0;
            cnt_q   <= SETUP_LD;
            state_q <= S_SETUP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        default: begin
          en_q    <= 1'b0;
          rdy_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Power/backlight enable is a plain one-cycle delay, unrelated to the FSM.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lcd_on_q <= 1'b0;
    end else begin
      lcd_on_q <= i_lcd_on;
    end
  end

  assign o_wr_rdy   = rdy_q;
  assign o_done     = done_q;
  assign o_lcd_on   = lcd_on_q;
  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;

endmodule

// File: tb/tb_lcd_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_wr_ctrl
// Self-checking bench for lcd_wr_ctrl. A reference model describes each write
// as "cycles elapsed since the accepting edge" and derives EN, ready, done and
// bus contents from the phase lengths with plain arithmetic. Directed steps
// cover the basic write, clear vs. normal waits, changing inputs while busy,
// back-to-back requests and reset during EN; a randomized phase follows.
// Honors LCD_INIT_EN (init sequence modelled as a queue of commands).
// -----------------------------------------------------------------------------
module tb_lcd_wr_ctrl;

  localparam int S   = 2;
  localparam int E   = 4;
  localparam int H   = 2;
  localparam int CMD = 10;
  localparam int CLR = 50;
  localparam int PWR = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       lcd_on = 1'b0;
  logic       wr_rdy;
  logic       done;
  logic       lcd_on_o;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  always #5 clk = ~clk;

  lcd_wr_ctrl #(
    .T_SETUP_CYC(S), .T_EN_CYC(E), .T_HOLD_CYC(H),
    .T_CMD_CYC(CMD), .T_CLR_CYC(CLR), .T_PWR_CYC(PWR)
  ) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_wr_vld(vld), .i_wr_rs(rs), .i_wr_data(data),
    .o_wr_rdy(wr_rdy), .o_done(done),
    .i_lcd_on(lcd_on), .o_lcd_on(lcd_on_o),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_busy;
  int         m_el;
  int         m_tot;
  logic [7:0] m_data;
  logic       m_rs;
  logic       m_done;
  logic       m_on;
  bit         m_init;
  logic [7:0] m_init_q[$];
  int         m_pwr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wait_for(input logic [7:0] d, input logic r);
    if (!r && d >= 8'h01 && d <= 8'h03) return CLR;
    return CMD;
  endfunction

  task automatic start_write(input logic [7:0] d, input logic r, input bit init);
    m_busy = 1;
    m_el   = 0;
    m_data = d;
    m_rs   = r;
    m_tot  = S + E + H + wait_for(d, r);
    m_init = init;
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_el   = 0;
    m_tot  = 0;
    m_data = 8'h00;
    m_rs   = 1'b0;
    m_done = 1'b0;
    m_on   = 1'b0;
    m_init = 0;
`ifdef LCD_INIT_EN
    m_init_q = '{8'h38, 8'h0C, 8'h01, 8'h06};
    m_pwr    = PWR;
`else
    m_init_q.delete();
    m_pwr    = 0;
`endif
  endtask

  // One clock edge of the reference model, using the inputs seen at the edge.
  task automatic model_edge();
    m_done = 1'b0;
    m_on   = lcd_on;
    if (m_pwr > 0) begin
      m_pwr--;
      if (m_pwr == 0) start_write(m_init_q.pop_front(), 1'b0, 1);
    end else if (!m_busy) begin
      if (vld) start_write(data, rs, 0);
    end else begin
      m_el++;
      if (m_el == m_tot) begin
        m_busy = 0;
        if (m_init) begin
          if (m_init_q.size() > 0) start_write(m_init_q.pop_front(), 1'b0, 1);
          else m_init = 0;
        end else begin
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("en",   lcd_en,   (m_busy && m_el >= S && m_el < S + E));
    check("rdy",  wr_rdy,   (!m_busy && m_pwr == 0));
    check("done", done,     m_done);
    check("data", lcd_data, m_data);
    check("rs",   lcd_rs,   m_rs);
    check("rw",   lcd_rw,   1'b0);
    check("on",   lcd_on_o, m_on);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (wr_rdy !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(tag, (n < 2000), 1'b1);
  endtask

  // Single-cycle request, then measure how many samples ready stays low.
  task automatic write_measure(input logic r, input logic [7:0] d, input int exp_busy, input string tag);
    int n = 0;
    rs = r; data = d; vld = 1'b1;
    tick();
    vld = 1'b0;
    check({tag, "_latch"}, {lcd_rs, lcd_data}, {r, d});
    while (wr_rdy === 1'b0 && n < 500) begin
      n++;
      tick();
    end
    check({tag, "_busy"}, n, exp_busy);
    check({tag, "_done_at_rdy"}, done, 1'b1);
  endtask

  initial begin
    int rises;
    int dones;
    int n;
    logic prev_en;

    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_ready("init_ready");

    // Basic write and clear vs. normal execution waits
    write_measure(1'b1, 8'h41, S + E + H + CMD, "w41");
    write_measure(1'b0, 8'h01, S + E + H + CLR, "clr");
    write_measure(1'b0, 8'h80, S + E + H + CMD, "w80");

    // Inputs changing while busy: only the value at the accept edge is written
    rs = 1'b0; data = 8'h30; vld = 1'b1;
    tick();
    rises = 0;
    prev_en = lcd_en;
    repeat (S + E + H + CMD - 1) begin
      data = (data == 8'h30) ? 8'h31 : 8'h30;
      rs = ~rs;
      tick();
      if (lcd_en && !prev_en) rises++;
      prev_en = lcd_en;
    end
    vld = 1'b0;
    tick();
    check("hold_one_pulse", rises, 1);
    check("hold_data", lcd_data, 8'h30);
    check("hold_done", done, 1'b1);

    // Four back-to-back requests with valid held high
    rises = 0; dones = 0; n = 0;
    prev_en = lcd_en;
    rs = 1'b1; data = 8'($urandom); vld = 1'b1;
    while (dones < 4 && n < 400) begin
      tick();
      n++;
      if (lcd_en && !prev_en) rises++;
      prev_en = lcd_en;
      if (done) begin
        dones++;
        data = 8'($urandom);
        if (dones == 4) vld = 1'b0;
      end
    end
    check("b2b_dones", dones, 4);
    check("b2b_pulses", rises, 4);
    tick();

    // Reset asserted in the middle of EN_HI
    rs = 1'b1; data = 8'h55; vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (S + 1) tick();
    check("rst_en_before", lcd_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_en_async", lcd_en, 1'b0);
    compare_all();
    tick();
    rst_n = 1'b1;
    tick();
    wait_ready("rst_ready");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      vld    = ($urandom_range(0, 3) == 0);
      rs     = 1'($urandom);
      data   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      lcd_on = 1'($urandom);
      tick();
    end
    vld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_wr_ctrl.md
Name: lcd_wr_ctrl

Overview:
- Hardware HD44780-style character-LCD write sequencer. Sits behind the LSU's LCD I/O register and is the consumer end of that interface.
- The CPU posts one byte plus an RS flag per request through a valid/ready handshake. The block generates the LCD bus timing: setup, EN pulse, hold, then the command execution wait.
- This removes software bit-banging of EN/RS/RW through the LCD register.

Parameters:
- T_SETUP_CYC, 2, cycles data/RS stable before EN rises (min 1)
- T_EN_CYC, 12, cycles EN held high (min 1)
- T_HOLD_CYC, 2, cycles data/RS held after EN falls (min 1)
- T_CMD_CYC, 2000, execution wait for normal writes (40 us at 50 MHz) (min 1)
- T_CLR_CYC, 82000, execution wait for clear/home commands (1.64 ms) (min 1)
- T_PWR_CYC, 750000, power-on delay, used only with LCD_INIT_EN (min 1)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  reset, asynchronous, active-low
- i_wr_vld  in  1  write request valid
- i_wr_rs  in  1  register select: 0 = command, 1 = data
- i_wr_data  in  8  byte to write
- o_wr_rdy  out  1  ready to accept a request
- o_done  out  1  one-cycle pulse when a write (including its wait) completes
- i_lcd_on  in  1  backlight/power enable from the CPU
- o_lcd_on  out  1  registered copy of i_lcd_on
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD R/W, constant 0 (write-only)
- o_lcd_en  out  1  LCD EN

Behaviour:
- Clock/reset: one clock i_clk; i_reset asynchronous, active-low.
- Reset values: o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_done=0. o_wr_rdy=1 without the macro, 0 with it. FSM=IDLE, counter=0.
- Outputs: all LCD outputs are registered; no combinational path from inputs to o_lcd_*. o_wr_rdy is high only in IDLE.
- States: IDLE, SETUP, EN_HI, HOLD, WAIT (plus PWR and INIT_* with the macro).
- IDLE: if i_wr_vld&&o_wr_rdy at an edge, latch i_wr_rs/i_wr_data onto o_lcd_rs/o_lcd_data, go to SETUP, load counter. i_wr_vld while not ready is ignored; no latching, no queuing.
- SETUP: T_SETUP_CYC cycles, EN=0, then EN_HI.
- EN_HI: o_lcd_en=1 for exactly T_EN_CYC cycles, then HOLD.
- HOLD: EN=0, data/RS unchanged, T_HOLD_CYC cycles, then WAIT.
- WAIT selection: T_CLR_CYC when latched rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_CMD_CYC.
- WAIT exit: after the selected count, return to IDLE and assert o_done for that single cycle.
- Busy window: o_wr_rdy is low for exactly T_SETUP_CYC+T_EN_CYC+T_HOLD_CYC+T_wait cycles after the accepting edge. It rises in the same cycle as o_done.
- Back-to-back: a request held valid is accepted at the first edge where o_wr_rdy=1.
- Data hold: o_lcd_data/o_lcd_rs retain the last written value in IDLE.
- Counter: down-counter sized $clog2 of the largest parameter +1; reloaded on each state entry, no wrap.
- o_lcd_on = i_lcd_on delayed one cycle; independent of the FSM.
- Reset mid-operation: o_lcd_en drops to 0 immediately (asynchronously) and all state returns to reset values. The interrupted write is discarded with no o_done.

Optional Feature:
- Macro LCD_INIT_EN.
- Defined:
  - After reset the FSM enters PWR for T_PWR_CYC cycles.
  - It then issues the commands 0x38, 0x0C, 0x01, 0x06 (rs=0) autonomously, each with the full SETUP/EN_HI/HOLD/WAIT sequence and the normal T_CLR_CYC rule for 0x01.
  - o_wr_rdy stays 0 throughout.
  - o_done does not pulse for init writes.
  - The FSM enters IDLE with o_wr_rdy=1 after the last init wait.
- Undefined: these states are absent; IDLE is entered directly from reset.

Test Plan (T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD=10, T_CLR=50, T_PWR=20):
- Reset released, one write rs=1 data=0x41 -> o_lcd_data=0x41, rs=1 the cycle after accept. EN high exactly 4 cycles, starting 2 cycles after data. o_wr_rdy low 18 cycles. o_done single pulse with rdy rise.
- rs=0 data=0x01, then rs=0 data=0x80 -> first busy 58 cycles, second busy 18 cycles.
- vld held high with data 0x30,0x31 changing while busy -> exactly one write, of the value sampled at the accept edge. Bus never changes during SETUP/EN_HI/HOLD.
- Four back-to-back requests with vld always high -> four EN pulses, four o_done pulses, each accepted on the rdy-rise cycle. o_lcd_rw=0 throughout.
- i_reset asserted during EN_HI -> o_lcd_en=0 before the next clock edge, no o_done, rdy=1 after release (macro off).
- LCD_INIT_EN defined -> rdy=0 for 20 cycles, then EN pulses carrying 0x38, 0x0C, 0x01, 0x06 in order. The 0x01 wait is 50 cycles. rdy=1 after completion, no o_done during init.
